// File: rtl/hash_data_unpack_pkg.sv
// Shared parameters, state encoding and datapath control bundle
// for the packed-vector to coefficient-RAM unpacker.
package hash_data_unpack_pkg;

    localparam int COEF_W   = 13;
    localparam int ADDR_W   = 11;
    localparam int MAX_COEF = 624;
    localparam int DATA_W   = COEF_W * MAX_COEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic load;
        logic shift;
        logic out_en;
    } dp_ctrl_t;

    function automatic logic over_range(
        input logic [ADDR_W-1:0] degp
    );
        return degp > ADDR_W'(MAX_COEF);
    endfunction

    function automatic logic [ADDR_W-1:0] eff_count(
        input logic [ADDR_W-1:0] degp
    );
        if (over_range(degp)) begin
            return ADDR_W'(MAX_COEF);
        end
        return degp;
    endfunction

endpackage

// File: rtl/hash_data_unpack_if.sv
// Request and RAM write-port bundle of the unpacker;
// master drives requests and grant, slave is the unpacker.
interface hash_data_unpack_if;
    import hash_data_unpack_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] degp;
    logic [DATA_W-1:0] data_in;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [COEF_W-1:0] mem_din;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start,
        output degp,
        output data_in,
        output mem_gnt,
        input  mem_we,
        input  mem_addr,
        input  mem_din,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  degp,
        input  data_in,
        input  mem_gnt,
        output mem_we,
        output mem_addr,
        output mem_din,
        output busy,
        output done,
        output err
    );

endinterface

// File: rtl/hash_unpack_dp.sv
// Unpacker datapath: shift register feeding the LSB word out,
// remaining-word counter and gated address/data outputs.
module hash_unpack_dp
    import hash_data_unpack_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  dp_ctrl_t          ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] neff_i,
    output logic              last_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [COEF_W-1:0] din_o
);

    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // Load a new vector, or drop the committed word and count down.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (ctrl_i.load) begin
            shreg_d = data_i;
            cnt_d   = neff_i;
        end else if (ctrl_i.shift) begin
            shreg_d = shreg_q >> COEF_W;
            cnt_d   = cnt_q - ADDR_W'(1);
        end
    end

    // Shift register and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last_o = (cnt_q == ADDR_W'(1));
    assign addr_o = ctrl_i.out_en ? cnt_q - ADDR_W'(1) : '0;
    assign din_o  = ctrl_i.out_en ? shreg_q[COEF_W-1:0] : '0;

endmodule

// File: rtl/hash_data_unpack.sv
// Writes a packed coefficient vector back to RAM one word per
// granted cycle, word 0 to the highest address, last word to 0.
module hash_data_unpack
    import hash_data_unpack_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    hash_data_unpack_if.slave bus
);

    state_e            state_q;
    state_e            state_d;
    logic              err_q;
    logic              err_d;
    dp_ctrl_t          ctrl;
    logic              we;
    logic              last;
    logic [ADDR_W-1:0] neff;

    assign neff = eff_count(bus.degp);

    // Next state, sticky error and datapath selects.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        ctrl    = '0;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ctrl.load = 1'b1;
                    err_d     = over_range(bus.degp);
                    if (neff == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                ctrl.out_en = 1'b1;
                we          = bus.mem_gnt;
                if (bus.mem_gnt) begin
                    ctrl.shift = 1'b1;
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    hash_unpack_dp u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .ctrl_i (ctrl),
        .data_i (bus.data_in),
        .neff_i (neff),
        .last_o (last),
        .addr_o (bus.mem_addr),
        .din_o  (bus.mem_din)
    );

    assign bus.mem_we = we;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.err    = err_q;

endmodule

// File: tb/tb_hash_data_unpack.sv
// Self-checking bench for hash_data_unpack: table vectors,
// random ops against a mapping model, and corner sequences.
module tb_hash_data_unpack;
    import hash_data_unpack_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hash_data_unpack_if ifc();

    hash_data_unpack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [COEF_W-1:0] d;
    } wr_t;

    typedef struct {
        int   degp;
        int   mode;
        logic exp_err;
        int   exp_nwr;
    } vec_t;

    int n_checks = 0;
    int n_fail = 0;

    wr_t  wlog[$];
    wr_t  exp_q[$];
    int   pat[$];
    logic [COEF_W-1:0] ram_tb [0:2047];
    int   stab_bad;
    int   we_bad;

    // Record every committed RAM write.
    always @(posedge clk) begin
        if (rst_n && ifc.mem_we) begin
            wlog.push_back({ifc.mem_addr, ifc.mem_din});
            ram_tb[ifc.mem_addr] = ifc.mem_din;
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_vec();
        logic [DATA_W-1:0] v;
        v = '0;
        for (int k = 0; k < MAX_COEF; k++) begin
            v[COEF_W*k +: COEF_W] = COEF_W'($urandom);
        end
        return v;
    endfunction

    // Word k lands at address neff-1-k; words beyond neff vanish.
    task automatic model(input int dg,
                         input logic [DATA_W-1:0] v);
        int neff;
        neff = (dg > MAX_COEF) ? MAX_COEF : dg;
        exp_q.delete();
        for (int k = 0; k < neff; k++) begin
            exp_q.push_back({ADDR_W'(neff - 1 - k),
                             v[COEF_W*k +: COEF_W]});
        end
    endtask

    // mode 0: grant always, 1: random grant, 2: grant from pat.
    task automatic run_op(input int dg,
                          input logic [DATA_W-1:0] v,
                          input int mode,
                          output int done_cyc,
                          output int busy_cnt);
        int   cyc;
        int   g;
        logic pg;
        logic hp;
        logic [ADDR_W-1:0] pa;
        logic [COEF_W-1:0] pd;
        wlog.delete();
        stab_bad = 0;
        we_bad = 0;
        done_cyc = -1;
        busy_cnt = 0;
        cyc = 0;
        hp = 1'b0;
        pg = 1'b1;
        pa = '0;
        pd = '0;
        ifc.start = 1'b1;
        ifc.degp = ADDR_W'(dg);
        ifc.data_in = v;
        ifc.mem_gnt = 1'b0;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        forever begin
            if (mode == 0) g = 1;
            else if (mode == 1) g = int'($urandom_range(0, 1));
            else g = (cyc < pat.size()) ? pat[cyc] : 1;
            ifc.mem_gnt = g[0];
            @(negedge clk);
            if (ifc.busy) busy_cnt++;
            if (ifc.done) begin
                done_cyc = cyc + 1;
                break;
            end
            if (ifc.mem_we !== g[0]) we_bad++;
            if (hp && !pg &&
                (ifc.mem_addr !== pa || ifc.mem_din !== pd))
                stab_bad++;
            pa = ifc.mem_addr;
            pd = ifc.mem_din;
            pg = g[0];
            hp = 1'b1;
            cyc++;
            if (cyc > 4000) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout: no done after %0d", cyc);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ifc.mem_gnt = 1'b0;
    endtask

    task automatic do_op(input string nm,
                         input int dg,
                         input logic [DATA_W-1:0] v,
                         input int mode,
                         input logic exp_err,
                         input int exp_nwr);
        int dc;
        int bc;
        int bad;
        model(dg, v);
        run_op(dg, v, mode, dc, bc);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= wlog.size() || wlog[i] !== exp_q[i]) bad++;
        end
        chk({nm, " nwr"}, wlog.size(), exp_nwr);
        chk({nm, " data"}, bad, 0);
        chk({nm, " err"}, {31'd0, ifc.err}, {31'd0, exp_err});
        chk({nm, " we"}, we_bad, 0);
        chk({nm, " stable"}, stab_bad, 0);
        chk({nm, " busy"}, bc, dc);
        chk({nm, " idle"}, {31'd0, ifc.busy}, 0);
        if (mode == 0) chk({nm, " lat"}, dc, exp_nwr + 1);
    endtask

    vec_t tbl[10];

    initial begin
        int dc;
        int bc;
        int bad;
        int dg;
        int r;
        logic [DATA_W-1:0] v;
        logic [COEF_W-1:0] orig [0:MAX_COEF-1];

        tbl[0] = '{3,    0, 1'b0, 3};
        tbl[1] = '{0,    0, 1'b0, 0};
        tbl[2] = '{1,    0, 1'b0, 1};
        tbl[3] = '{1,    1, 1'b0, 1};
        tbl[4] = '{17,   1, 1'b0, 17};
        tbl[5] = '{623,  1, 1'b0, 623};
        tbl[6] = '{624,  0, 1'b0, 624};
        tbl[7] = '{625,  1, 1'b1, 624};
        tbl[8] = '{2047, 0, 1'b1, 624};
        tbl[9] = '{5,    1, 1'b0, 5};

        ifc.start = 1'b0;
        ifc.degp = '0;
        ifc.data_in = '0;
        ifc.mem_gnt = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst we", {31'd0, ifc.mem_we}, 0);
        chk("rst addr", {21'd0, ifc.mem_addr}, 0);
        chk("rst din", {19'd0, ifc.mem_din}, 0);
        chk("rst busy", {31'd0, ifc.busy}, 0);
        chk("rst done", {31'd0, ifc.done}, 0);
        chk("rst err", {31'd0, ifc.err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifc.mem_gnt = 1'b0;
        @(posedge clk); #1;

        // Table of basic and boundary vectors.
        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("tbl%0d", i), tbl[i].degp,
                  rand_vec(), tbl[i].mode,
                  tbl[i].exp_err, tbl[i].exp_nwr);
        end

        // Random ops against the model.
        for (int i = 0; i < 12; i++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0) dg = int'($urandom_range(625, 2047));
            else dg = int'($urandom_range(0, 60));
            do_op($sformatf("rnd%0d", i), dg, rand_vec(), 1,
                  dg > MAX_COEF,
                  (dg > MAX_COEF) ? MAX_COEF : dg);
        end

        // Three known words.
        v = '0;
        v[12:0] = 13'h00AA;
        v[25:13] = 13'h0155;
        v[38:26] = 13'h1FFF;
        v[51:39] = 13'h0777;
        run_op(3, v, 0, dc, bc);
        chk("k3 nwr", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("k3 w0", {8'd0, wlog[0]}, {8'd0, 11'd2, 13'h00AA});
            chk("k3 w1", {8'd0, wlog[1]}, {8'd0, 11'd1, 13'h0155});
            chk("k3 w2", {8'd0, wlog[2]}, {8'd0, 11'd0, 13'h1FFF});
        end
        chk("k3 done", dc, 4);
        chk("k3 err", {31'd0, ifc.err}, 0);

        // Zero-length request.
        run_op(0, v, 0, dc, bc);
        chk("z nwr", wlog.size(), 0);
        chk("z done", dc, 1);
        chk("z busy", bc, 1);

        // Grant pattern with stalls.
        pat = '{1, 0, 0, 1, 1, 0, 1};
        v = rand_vec();
        run_op(4, v, 2, dc, bc);
        chk("g nwr", wlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wlog.size()) begin
                chk($sformatf("g a%0d", i),
                    {21'd0, wlog[i].a}, 3 - i);
                chk($sformatf("g d%0d", i),
                    {19'd0, wlog[i].d},
                    {19'd0, v[COEF_W*i +: COEF_W]});
            end
        end
        chk("g stable", stab_bad, 0);
        chk("g done", dc, 8);

        // Over-range sets err, next accepted start clears it.
        run_op(700, rand_vec(), 0, dc, bc);
        chk("e nwr", wlog.size(), 624);
        if (wlog.size() == 624) begin
            chk("e first", {21'd0, wlog[0].a}, 623);
            chk("e last", {21'd0, wlog[623].a}, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("e sticky", {31'd0, ifc.err}, 1);
        run_op(5, rand_vec(), 0, dc, bc);
        chk("e clear", {31'd0, ifc.err}, 0);
        chk("e5 nwr", wlog.size(), 5);

        // Round trip: packer image address 0 is most significant.
        for (int a = 0; a < 2048; a++) ram_tb[a] = '0;
        for (int a = 0; a < MAX_COEF; a++) orig[a] = COEF_W'($urandom);
        v = '0;
        for (int k = 0; k < MAX_COEF; k++) begin
            v[COEF_W*k +: COEF_W] = orig[MAX_COEF - 1 - k];
        end
        run_op(MAX_COEF, v, 1, dc, bc);
        bad = 0;
        for (int a = 0; a < MAX_COEF; a++) begin
            if (ram_tb[a] !== orig[a]) bad++;
        end
        chk("rt ram", bad, 0);

        // Reset mid-write, with an ignored start while busy.
        wlog.delete();
        ifc.start = 1'b1;
        ifc.degp = 11'd5;
        ifc.data_in = rand_vec();
        ifc.mem_gnt = 1'b1;
        @(posedge clk); #1;
        ifc.degp = 11'd0;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("r we", {31'd0, ifc.mem_we}, 0);
        chk("r busy", {31'd0, ifc.busy}, 0);
        chk("r done", {31'd0, ifc.done}, 0);
        chk("r addr", {21'd0, ifc.mem_addr}, 0);
        chk("r din", {19'd0, ifc.mem_din}, 0);
        chk("r nwr", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("r a0", {21'd0, wlog[0].a}, 4);
            chk("r a1", {21'd0, wlog[1].a}, 3);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("r resume", wlog.size(), 2);
        chk("r idle", {31'd0, ifc.busy}, 0);
        ifc.mem_gnt = 1'b0;

        // Start coincident with done is ignored.
        wlog.delete();
        ifc.start = 1'b1;
        ifc.degp = 11'd2;
        ifc.data_in = rand_vec();
        ifc.mem_gnt = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ifc.start = 1'b1;
        ifc.degp = 11'd3;
        @(negedge clk);
        chk("c done", {31'd0, ifc.done}, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("c ignored", {31'd0, ifc.busy}, 0);
        @(posedge clk); #1;
        ifc.start = 1'b0;
        @(negedge clk);
        chk("c accept", {31'd0, ifc.busy}, 1);
        r = 0;
        while (!ifc.done && r < 20) begin
            @(negedge clk);
            r++;
        end
        chk("c fin", {31'd0, ifc.done}, 1);
        chk("c nwr", wlog.size(), 5);
        if (wlog.size() == 5) begin
            chk("c a2", {21'd0, wlog[2].a}, 2);
        end
        @(posedge clk); #1;
        ifc.mem_gnt = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
